// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports, status and DataMemory side of the dmem arbiter
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port DataMemory arbiter; DMEM_ARB_RR_EN selects round-robin, else port 1 priority
module dmem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       owner;
  logic       last;
  logic       winner;

`ifdef DMEM_ARB_RR_EN
  // On a tie the port that did not own the previous access wins.
  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) winner = ~last;
  end
`else
  logic unusedLast;
  assign winner     = bus.req1;
  assign unusedLast = last;
`endif

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      owner         <= 1'b0;
      last          <= 1'b1;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= AW'(0);
      bus.mem_wdata <= DW'(0);
      bus.rdata     <= DW'(0);
    end else begin
      bus.mem_en <= 1'b0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner         <= winner;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= winner ? bus.we1    : bus.we0;
            bus.mem_addr  <= winner ? bus.addr1  : bus.addr0;
            bus.mem_wdata <= winner ? bus.wdata1 : bus.wdata0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= 4'(MEM_LAT - 1);
          state <= (MEM_LAT == 1) ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE: begin
          // DONE is the cycle in which mem_rdata is valid; rdata and ack appear together next cycle.
          if (!bus.mem_we) bus.rdata <= bus.mem_rdata;
          bus.ack0 <= ~owner;
          bus.ack1 <= owner;
          last     <= owner;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (MEM_LAT 1 random traffic, MEM_LAT 3 directed)
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  typedef struct { bit port; int cyc; logic [DW-1:0] rdata; } ackT;
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } memT;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst3 = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT))  dut  (.clk(clk), .rst(rst),  .bus(bus));
  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit running = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] memInit(input logic [AW-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // DataMemory model for the MEM_LAT=1 instance; garbage outside the valid cycle
  logic [DW-1:0] envMem [logic [AW-1:0]];
  logic [DW-1:0] pipeData [16];
  int            pipeCyc  [16];
  always @(negedge clk) begin
    if (bus.mem_en) begin
      pipeCyc[(cyc + LAT) % 16]  = cyc + LAT;
      pipeData[(cyc + LAT) % 16] = envMem.exists(bus.mem_addr) ? envMem[bus.mem_addr] : memInit(bus.mem_addr);
      if (bus.mem_we) envMem[bus.mem_addr] = bus.mem_wdata;
    end
  end
  always @(posedge clk) begin
    #1;
    if (pipeCyc[cyc % 16] == cyc) bus.mem_rdata = pipeData[cyc % 16];
    else bus.mem_rdata = DW'($urandom);
  end

  int en3Cyc = -100;
  always @(negedge clk) if (bus3.mem_en) en3Cyc = cyc;
  always @(posedge clk) begin
    #1;
    bus3.mem_rdata = (cyc == en3Cyc + LAT3) ? (16'hBEEF ^ bus3.mem_addr) : 16'h0000;
  end

  // Reference model state
  ackT           expAck[$];
  memT           expMem[$];
  logic [DW-1:0] refMem [logic [AW-1:0]];
  bit            rq[2], wEn[2], hold[2], inflight[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] wd[2];
  int            dropAt[2];
  int            freeEdge = 0;
  int            lastGrant = -100;
  bit            lastOwner = 1'b1;
  bit            scramble = 1'b0;
  bit            expBusyNow = 1'b0;
  logic [DW-1:0] modelRdata = '0;
  logic [DW-1:0] monRdata = '0;

  task automatic drive();
    bus.req0 = rq[0]; bus.we0 = wEn[0]; bus.addr0 = ad[0]; bus.wdata0 = wd[0];
    bus.req1 = rq[1]; bus.we1 = wEn[1]; bus.addr1 = ad[1]; bus.wdata1 = wd[1];
  endtask

  task automatic newCmd(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit h);
    wEn[p] = we; ad[p] = a; wd[p] = d; hold[p] = h; rq[p] = 1'b1;
  endtask

  // One clock of the model: an idle arbiter grants at the edge opening cycle g, acks in g+LAT+1, idle again at g+LAT+2.
  task automatic step();
    bit w;
    logic [DW-1:0] rd;
    @(posedge clk); #1;
    if (cyc >= freeEdge && (rq[0] || rq[1])) begin
`ifdef DMEM_ARB_RR_EN
      w = (rq[0] && rq[1]) ? ~lastOwner : rq[1];
`else
      w = rq[1];
`endif
      expMem.push_back('{wEn[w], ad[w], wd[w], cyc});
      if (wEn[w]) begin
        refMem[ad[w]] = wd[w];
        rd = modelRdata;
      end else begin
        rd = refMem.exists(ad[w]) ? refMem[ad[w]] : memInit(ad[w]);
        modelRdata = rd;
      end
      expAck.push_back('{w, cyc + LAT + 1, rd});
      lastOwner = w; lastGrant = cyc; freeEdge = cyc + LAT + 2;
      inflight[w] = 1'b1; dropAt[w] = cyc + LAT + 1;
    end
    for (int p = 0; p < 2; p++) begin
      if (inflight[p] && cyc == dropAt[p]) begin
        inflight[p] = 1'b0;
        if (!hold[p]) rq[p] = 1'b0;
      end else if (inflight[p] && !hold[p] && scramble && $urandom_range(0, 1) == 1) begin
        wEn[p] = $urandom_range(0, 1); ad[p] = AW'($urandom); wd[p] = DW'($urandom);
      end
    end
    expBusyNow = (cyc >= lastGrant) && (cyc <= lastGrant + LAT);
    drive();
  endtask

  ackT monA;
  memT monM;
  always @(negedge clk) begin
    if (running) begin
      check("busy", bus.busy, expBusyNow);
      check("ack_onehot", bus.ack0 & bus.ack1, 0);
      if (bus.ack0 || bus.ack1) begin
        if (expAck.size() == 0) check("ack_unexpected", bus.ack0 | bus.ack1, 0);
        else begin
          monA = expAck.pop_front();
          check("ack_port", bus.ack1, monA.port);
          check("ack_cycle", cyc, monA.cyc);
          check("ack_rdata", bus.rdata, monA.rdata);
          monRdata = monA.rdata;
        end
      end else check("rdata_hold", bus.rdata, monRdata);
      if (expAck.size() > 0 && cyc > expAck[0].cyc) begin
        check("ack_missing", cyc, expAck[0].cyc);
        void'(expAck.pop_front());
      end
      if (bus.mem_en) begin
        if (expMem.size() == 0) check("mem_en_unexpected", bus.mem_en, 0);
        else begin
          monM = expMem.pop_front();
          check("mem_en_cycle", cyc, monM.cyc);
          check("mem_we", bus.mem_we, monM.we);
          check("mem_addr", bus.mem_addr, monM.addr);
          if (monM.we) check("mem_wdata", bus.mem_wdata, monM.wdata);
        end
      end
      if (expMem.size() > 0 && cyc > expMem[0].cyc) begin
        check("mem_en_missing", cyc, expMem[0].cyc);
        void'(expMem.pop_front());
      end
    end
  end

  int n, ackAt, busyCnt;

  initial begin
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; wEn[p] = 0; ad[p] = '0; wd[p] = '0; hold[p] = 0; inflight[p] = 0; dropAt[p] = -1;
    end
    drive();
    bus3.req0 = 0; bus3.we0 = 0; bus3.addr0 = '0; bus3.wdata0 = '0;
    bus3.req1 = 0; bus3.we1 = 0; bus3.addr1 = '0; bus3.wdata1 = '0;
    #2 rst = 1'b1; rst3 = 1'b1;
    #1;
    check("reset_ctrl", {bus.ack0, bus.ack1, bus.busy, bus.mem_en, bus.mem_we}, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_mem_wdata", bus.mem_wdata, 0);
    check("reset_rdata", bus.rdata, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;
    running = 1'b1;

    envMem[16'h0001] = 16'hABCD;
    refMem[16'h0001] = 16'hABCD;
    newCmd(0, 1'b0, 16'h0001, 16'h0000, 1'b0); drive();
    repeat (6) step();
    newCmd(1, 1'b1, 16'h0010, 16'h1234, 1'b0); drive();
    repeat (6) step();
    newCmd(1, 1'b0, 16'h0010, 16'h0000, 1'b0); drive();
    repeat (6) step();
    newCmd(0, 1'b0, 16'h0002, 16'h0000, 1'b1);
    newCmd(1, 1'b0, 16'h0003, 16'h0000, 1'b1); drive();
    repeat (4 * (LAT + 2)) step();
    hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (20) step();
    newCmd(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0); drive();
    step();
    step();
    newCmd(1, 1'b0, 16'h0001, 16'h0000, 1'b0); drive();
    repeat (12) step();

    scramble = 1'b1;
    repeat (3000) begin
      step();
      for (int p = 0; p < 2; p++)
        if (!rq[p] && !inflight[p] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 4))
            0:       newCmd(p, 1'($urandom_range(0, 1)), 16'h0000, DW'($urandom), $urandom_range(0, 9) == 0);
            1:       newCmd(p, 1'($urandom_range(0, 1)), 16'h0001, DW'($urandom), $urandom_range(0, 9) == 0);
            2:       newCmd(p, 1'($urandom_range(0, 1)), 16'h0010, DW'($urandom), $urandom_range(0, 9) == 0);
            3:       newCmd(p, 1'($urandom_range(0, 1)), 16'hFFFF, DW'($urandom), $urandom_range(0, 9) == 0);
            default: newCmd(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), $urandom_range(0, 9) == 0);
          endcase
        end
      drive();
    end
    hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (40) step();
    check("drain_ack_queue", expAck.size(), 0);
    check("drain_mem_queue", expMem.size(), 0);

    // MEM_LAT=3 instance: latency, busy span, read capture
    @(posedge clk); #1;
    bus3.req0 = 1'b1; bus3.we0 = 1'b0; bus3.addr0 = 16'h0042; n = cyc;
    busyCnt = 0; ackAt = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus3.busy) busyCnt++;
      check("t4_no_ack1", bus3.ack1, 0);
      if (bus3.ack0) begin
        ackAt = cyc;
        check("t4_rdata", bus3.rdata, 16'hBEEF ^ 16'h0042);
        bus3.req0 = 1'b0;
      end
    end
    check("t4_ack_cycle", ackAt, n + 5);
    check("t4_busy_cycles", busyCnt, 4);

    // Reset while waiting on memory: access lost, outputs back to reset values at once
    @(posedge clk); #1;
    bus3.req0 = 1'b1; bus3.addr0 = 16'h0077;
    repeat (3) @(negedge clk);
    check("t5_in_wait", bus3.busy, 1);
    rst3 = 1'b1; bus3.req0 = 1'b0;
    #1;
    check("t5_rst_ctrl", {bus3.ack0, bus3.ack1, bus3.busy, bus3.mem_en, bus3.mem_we}, 0);
    check("t5_rst_mem_addr", bus3.mem_addr, 0);
    check("t5_rst_mem_wdata", bus3.mem_wdata, 0);
    check("t5_rst_rdata", bus3.rdata, 0);
    @(negedge clk); rst3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_ack", bus3.ack0 | bus3.ack1, 0);
    end
    @(posedge clk); #1;
    bus3.req0 = 1'b1; bus3.we0 = 1'b1; bus3.addr0 = 16'hFFFF; bus3.wdata0 = 16'h5555; n = cyc;
    ackAt = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus3.mem_en) begin
        check("t5_mem_we", bus3.mem_we, 1);
        check("t5_mem_addr", bus3.mem_addr, 16'hFFFF);
        check("t5_mem_wdata", bus3.mem_wdata, 16'h5555);
      end
      if (bus3.ack0) begin
        ackAt = cyc;
        check("t5_write_rdata", bus3.rdata, 0);
        bus3.req0 = 1'b0;
      end
    end
    check("t5_recover_ack_cycle", ackAt, n + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
